// File: rtl/debounce_pkg.sv
// debounce_pkg: shared types and constants for the debounce_sync input conditioner.
// State encoding: bit1 = current stable (accepted) level, bit0 = qualifying a change.
package debounce_pkg;

  typedef enum logic [1:0] {
    IDLE_LOW  = 2'b00,
    WAIT_HIGH = 2'b01,
    IDLE_HIGH = 2'b10,
    WAIT_LOW  = 2'b11
  } db_state_t;

  // Width of the optional abort counter.
  localparam int GLITCH_CNT_W = 8;

endpackage

// File: rtl/debounce_sync_sync_chain.sv
// sync_chain: STAGES-deep shift of async-reset flops bringing d into the clk domain.
module sync_chain #(
  parameter int STAGES = 2
) (
  input  logic clk,
  input  logic rst,
  input  logic d,
  output logic q
);

  logic [STAGES-1:0] stage_reg;

  generate
    for (genvar gi = 0; gi < STAGES; gi++) begin : g_stage
      if (gi == 0) begin : g_first
        // First stage samples the raw asynchronous input.
        always_ff @(posedge clk or posedge rst) begin
          if (rst) stage_reg[gi] <= 1'b0;
          else     stage_reg[gi] <= d;
        end
      end else begin : g_rest
        // Later stages give the first stage time to resolve metastability.
        always_ff @(posedge clk or posedge rst) begin
          if (rst) stage_reg[gi] <= 1'b0;
          else     stage_reg[gi] <= stage_reg[gi-1];
        end
      end
    end
  endgenerate

  assign q = stage_reg[STAGES-1];

endmodule

// File: rtl/debounce_sync.sv
// debounce_sync: synchronizes a bouncy async level, accepts a new value only after
// DEBOUNCE_CYCLES consecutive synchronized cycles, and emits registered rise/fall pulses.
// Optional feature (macro DEBOUNCE_GLITCH_CNT_EN): adds a saturating glitch_cnt output
// counting every aborted qualification.
module debounce_sync
  import debounce_pkg::*;
#(
  parameter int SYNC_STAGES     = 2,
  parameter int DEBOUNCE_CYCLES = 4
) (
  input  logic clk,
  input  logic rst,
  input  logic din,
  output logic dout,
  output logic rise_pulse,
  output logic fall_pulse,
`ifdef DEBOUNCE_GLITCH_CNT_EN
  output logic busy,
  output logic [GLITCH_CNT_W-1:0] glitch_cnt
`else
  output logic busy
`endif
);

  localparam int CNT_W = $clog2(DEBOUNCE_CYCLES + 1);
  localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(DEBOUNCE_CYCLES - 1);
  localparam logic [CNT_W-1:0] CNT_ONE  = CNT_W'(1);

  logic             s;
  db_state_t        state_reg, state_next;
  logic [CNT_W-1:0] cnt_reg, cnt_next;
  logic             rise_reg, rise_next;
  logic             fall_reg, fall_next;

  sync_chain #(.STAGES(SYNC_STAGES)) u_sync (
    .clk (clk),
    .rst (rst),
    .d   (din),
    .q   (s)
  );

  // State, qualification counter and pulse registers.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_reg <= IDLE_LOW;
      cnt_reg   <= '0;
      rise_reg  <= 1'b0;
      fall_reg  <= 1'b0;
    end else begin
      state_reg <= state_next;
      cnt_reg   <= cnt_next;
      rise_reg  <= rise_next;
      fall_reg  <= fall_next;
    end
  end

  // Next-state logic: any reversal of s while waiting drops back to idle with no credit.
  always_comb begin
    state_next = state_reg;
    cnt_next   = cnt_reg;
    rise_next  = 1'b0;
    fall_next  = 1'b0;
    case (state_reg)
      IDLE_LOW: begin
        if (s) begin
          state_next = WAIT_HIGH;
          cnt_next   = CNT_ONE;
        end else begin
          cnt_next = '0;
        end
      end
      WAIT_HIGH: begin
        if (!s) begin
          state_next = IDLE_LOW;
          cnt_next   = '0;
        end else if (cnt_reg == CNT_LAST) begin
          state_next = IDLE_HIGH;
          cnt_next   = '0;
          rise_next  = 1'b1;
        end else begin
          cnt_next = cnt_reg + CNT_ONE;
        end
      end
      IDLE_HIGH: begin
        if (!s) begin
          state_next = WAIT_LOW;
          cnt_next   = CNT_ONE;
        end else begin
          cnt_next = '0;
        end
      end
      WAIT_LOW: begin
        if (s) begin
          state_next = IDLE_HIGH;
          cnt_next   = '0;
        end else if (cnt_reg == CNT_LAST) begin
          state_next = IDLE_LOW;
          cnt_next   = '0;
          fall_next  = 1'b1;
        end else begin
          cnt_next = cnt_reg + CNT_ONE;
        end
      end
      default: begin
        state_next = IDLE_LOW;
        cnt_next   = '0;
      end
    endcase
  end

  // Outputs are decoded straight from registers: no combinational path from din.
  assign dout       = state_reg[1];
  assign busy       = state_reg[0];
  assign rise_pulse = rise_reg;
  assign fall_pulse = fall_reg;

`ifdef DEBOUNCE_GLITCH_CNT_EN
  logic                    abort;
  logic [GLITCH_CNT_W-1:0] glitch_cnt_reg;

  assign abort = ((state_reg == WAIT_HIGH) && !s) || ((state_reg == WAIT_LOW) && s);

  // Saturating count of aborted qualifications.
  always_ff @(posedge clk or posedge rst) begin
    if (rst)
      glitch_cnt_reg <= '0;
    else if (abort && (glitch_cnt_reg != '1))
      glitch_cnt_reg <= glitch_cnt_reg + GLITCH_CNT_W'(1);
  end

  assign glitch_cnt = glitch_cnt_reg;
`endif

endmodule
